// File: rtl/eth_types_pkg.sv
// eth_types_pkg: shared Ethernet constants and state types
// used by the TX-side frame path.
package eth_types_pkg;
   localparam int ETH_IFG_BYTES    = 12;
   localparam int ETH_MAX_FRAME    = 1514;
   localparam int ETH_CLK_PER_BYTE = 4;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_GRANT,
      ARB_IFG
   } tx_arb_states;
endpackage

// File: rtl/eth_tx_arbiter_if.sv
// eth_tx_arbiter_if: request/grant and byte-stream bundle between
// the two frame builders, the TX arbiter and the RMII serializer.
interface eth_tx_arbiter_if;
   logic [1:0] req;
   logic [1:0] grant;
   logic [7:0] src0_data;
   logic [7:0] src1_data;
   logic       src0_valid;
   logic       src1_valid;
   logic       src0_last;
   logic       src1_last;
   logic [1:0] src_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       tx_ready;
   logic       tx_abort;
   logic       busy;

   modport master (
      input  req,
      input  src0_data, src1_data,
      input  src0_valid, src1_valid,
      input  src0_last, src1_last,
      input  tx_ready,
      output grant, src_ready,
      output tx_data, tx_valid, tx_last,
      output tx_abort, busy
   );

   modport slave (
      output req,
      output src0_data, src1_data,
      output src0_valid, src1_valid,
      output src0_last, src1_last,
      output tx_ready,
      input  grant, src_ready,
      input  tx_data, tx_valid, tx_last,
      input  tx_abort, busy
   );
endinterface

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: round-robin whole-frame arbiter for the RMII TX byte
// path, with inter-frame gap and stall/overrun watchdog abort.
module eth_tx_arbiter
   import eth_types_pkg::*;
#(
   parameter int IFG_CYCLES      = ETH_IFG_BYTES * ETH_CLK_PER_BYTE,
   parameter int TIMEOUT_CYCLES  = 256,
   parameter int MAX_FRAME_BYTES = ETH_MAX_FRAME
) (
   input logic              clk,
   input logic              resetn,
   eth_tx_arbiter_if.master bus
);
   localparam int BW = $clog2(MAX_FRAME_BYTES + 1);
   localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int GW = $clog2(IFG_CYCLES + 1);

   tx_arb_states  state, state_n;
   logic [1:0]    grant_q, grant_n;
   logic          last_q, last_n;
   logic [BW-1:0] byte_q, byte_n;
   logic [SW-1:0] stall_q, stall_n;
   logic [GW-1:0] gap_q, gap_n;
   logic          abort_q, abort_n;
   logic          pick;
   logic          hs;
   logic          end_frame;

   assign bus.grant     = grant_q;
   assign bus.src_ready = grant_q & {2{bus.tx_ready}};
   assign bus.tx_abort  = abort_q;
   assign bus.busy      = (state != ARB_IDLE);
   assign hs            = bus.tx_valid & bus.tx_ready;

   always_comb begin
      bus.tx_data  = '0;
      bus.tx_valid = 1'b0;
      bus.tx_last  = 1'b0;
      unique case (1'b1)
         grant_q[0]: begin
            bus.tx_data  = bus.src0_data;
            bus.tx_valid = bus.src0_valid;
            bus.tx_last  = bus.src0_last;
         end
         grant_q[1]: begin
            bus.tx_data  = bus.src1_data;
            bus.tx_valid = bus.src1_valid;
            bus.tx_last  = bus.src1_last;
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      state_n   = state;
      grant_n   = grant_q;
      last_n    = last_q;
      byte_n    = byte_q;
      stall_n   = stall_q;
      gap_n     = gap_q;
      abort_n   = 1'b0;
      end_frame = 1'b0;
      // on contention favour whichever source was not served last
      pick = (bus.req == 2'b11) ? ~last_q : bus.req[1];
      unique case (state)
         ARB_IDLE: begin
            byte_n  = '0;
            stall_n = '0;
            if (bus.req != 2'b00) begin
               grant_n = pick ? 2'b10 : 2'b01;
               last_n  = pick;
               state_n = ARB_GRANT;
            end
         end
         ARB_GRANT: begin
            if (hs) begin
               stall_n = '0;
               if (bus.tx_last) begin
                  end_frame = 1'b1;
               end else if (byte_q == BW'(MAX_FRAME_BYTES)) begin
                  end_frame = 1'b1;
                  abort_n   = 1'b1;
               end else begin
                  byte_n = byte_q + BW'(1);
               end
            end else if (stall_q == SW'(TIMEOUT_CYCLES - 1)) begin
               end_frame = 1'b1;
               abort_n   = 1'b1;
            end else begin
               stall_n = stall_q + SW'(1);
            end
            if (end_frame) begin
               grant_n = '0;
               gap_n   = GW'(IFG_CYCLES - 1);
               state_n = ARB_IFG;
            end
         end
         ARB_IFG: begin
            if (gap_q == '0) state_n = ARB_IDLE;
            else gap_n = gap_q - GW'(1);
         end
         default: begin
            state_n = ARB_IDLE;
            grant_n = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= ARB_IDLE;
         grant_q <= '0;
         last_q  <= 1'b1;
         byte_q  <= '0;
         stall_q <= '0;
         gap_q   <= '0;
         abort_q <= 1'b0;
      end else begin
         state   <= state_n;
         grant_q <= grant_n;
         last_q  <= last_n;
         byte_q  <= byte_n;
         stall_q <= stall_n;
         gap_q   <= gap_n;
         abort_q <= abort_n;
      end
   end
endmodule
